spi_tx_fifo_master: RTL and testbench

Parametrised SPI transmit master for the SSD1331 OLED path. It runs on the system clock and generates SCK internally through a programmable divider. It buffers command/data words in an internal FIFO, each tagged with a D/C bit. Queued words go out back-to-back under one CS assertion, with configurable bit order and an inter-frame CS gap. It sits between the display controller FSM and the OLED pins (SCK, MOSI, CS, DC).

---
 rtl/spi_tx_fifo_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_tx_fifo_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo_master.sv
// spi_tx_fifo_master
//
// SPI transmit master for the SSD1331 OLED path. Words pushed by the display
// controller are queued in a small FIFO together with their D/C tag, then
// shifted out on SCK/MOSI. Queued words go back-to-back under a single CS
// assertion. CS is held high for CS_GAP cycles once the queue runs dry.
// SCK is derived from i_CLK through a half-period divider and idles high.
// The slave samples MOSI on the rising edge of SCK.
//
// Ports
//   i_CLK    system clock, all logic on its rising edge
//   i_RST    asynchronous active-high reset
//   i_DATA   word to queue (WIDTH bits)
//   i_DC     D/C tag for i_DATA (0 command, 1 data)
//   i_VALID  push request, accepted when o_READY is high
//   o_READY  FIFO not full
//   o_SCK    serial clock, idles high
//   o_MOSI   serial data, updated only on SCK falling edges
//   o_CS     chip select, active low
//   o_DC     D/C tag of the word currently on the wire
//   o_DONE   one-cycle pulse when the last bit of a word completes
//   o_BUSY   high whenever the serialiser is not idle
//   o_COUNT  FIFO occupancy
module spi_tx_fifo_master #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CLK_DIV   = 2,
    parameter int LSB_FIRST = 0,
    parameter int CS_GAP    = 2
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    input  logic [WIDTH-1:0]           i_DATA,
    input  logic                       i_DC,
    input  logic                       i_VALID,
    output logic                       o_READY,
    output logic                       o_SCK,
    output logic                       o_MOSI,
    output logic                       o_CS,
    output logic                       o_DC,
    output logic                       o_DONE,
    output logic                       o_BUSY,
    output logic [$clog2(DEPTH+1)-1:0] o_COUNT
);

    localparam int COUNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [BIT_W-1:0]   BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0]   DIV_LOAD   = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0]   GAP_LOAD   = TMR_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Bit presented first on the wire for a freshly loaded or shifted word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    logic [WIDTH-1:0]   data_mem_r [DEPTH];
    logic               dc_mem_r   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [COUNT_W-1:0] count_r;
    logic               ready_r;

    state_t             state_r;
    logic [TMR_W-1:0]   tmr_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [WIDTH-1:0]   shift_r;
    logic               sck_r;
    logic               mosi_r;
    logic               cs_r;
    logic               dc_r;
    logic               done_r;
    logic               busy_r;

    logic               push_s;
    logic               pop_s;
    logic               phase_end_s;
    logic               last_bit_s;
    logic               fifo_empty_s;
    logic [COUNT_W-1:0] count_next_s;
    logic [WIDTH-1:0]   head_data_s;
    logic               head_dc_s;
    logic [WIDTH-1:0]   shifted_s;

    assign head_data_s  = data_mem_r[rd_ptr_r];
    assign head_dc_s    = dc_mem_r[rd_ptr_r];
    assign phase_end_s  = (tmr_r == '0);
    assign last_bit_s   = (bit_cnt_r == LAST_BIT);
    assign fifo_empty_s = (count_r == '0);
    assign shifted_s    = (LSB_FIRST != 0) ? (shift_r >> 1'b1) : (shift_r << 1'b1);
    // ready_r already mirrors "count != DEPTH", so a push while full is dropped.
    assign push_s       = i_VALID && ready_r;

    // Pop when IDLE starts a frame or when a word ends with more queued behind it.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_HIGH: pop_s = phase_end_s && last_bit_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + COUNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - COUNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; contents need no reset because the pointers are flushed.
    always_ff @(posedge i_CLK) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= i_DATA;
            dc_mem_r[wr_ptr_r]   <= i_DC;
        end
    end

    // FIFO pointers, occupancy and registered ready flag.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != FULL_COUNT);
        end
    end

    // Serialiser FSM; every pin-facing output is a register written here.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_r   <= ST_IDLE;
            tmr_r     <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            sck_r     <= 1'b1;
            mosi_r    <= 1'b0;
            cs_r      <= 1'b1;
            dc_r      <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        shift_r   <= head_data_s;
                        mosi_r    <= first_bit(head_data_s);
                        dc_r      <= head_dc_s;
                        bit_cnt_r <= '0;
                        cs_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        tmr_r     <= DIV_LOAD;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_end_s) begin
                        sck_r   <= 1'b0;
                        tmr_r   <= DIV_LOAD;
                        state_r <= ST_LOW;
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                ST_LOW: begin
                    if (phase_end_s) begin
                        sck_r   <= 1'b1;
                        tmr_r   <= DIV_LOAD;
                        state_r <= ST_HIGH;
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                ST_HIGH: begin
                    if (phase_end_s) begin
                        tmr_r <= DIV_LOAD;
                        if (!last_bit_s) begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            shift_r   <= shifted_s;
                            mosi_r    <= first_bit(shifted_s);
                            sck_r     <= 1'b0;
                            state_r   <= ST_LOW;
                        end else begin
                            done_r <= 1'b1;
                            if (!fifo_empty_s) begin
                                // Chain the next word without releasing CS or re-running SETUP.
                                shift_r   <= head_data_s;
                                mosi_r    <= first_bit(head_data_s);
                                dc_r      <= head_dc_s;
                                bit_cnt_r <= '0;
                                sck_r     <= 1'b0;
                                state_r   <= ST_LOW;
                            end else begin
                                cs_r    <= 1'b1;
                                tmr_r   <= GAP_LOAD;
                                state_r <= ST_GAP;
                            end
                        end
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                ST_GAP: begin
                    if (phase_end_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sck_r   <= 1'b1;
                    cs_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_READY = ready_r;
    assign o_COUNT = count_r;
    assign o_SCK   = sck_r;
    assign o_MOSI  = mosi_r;
    assign o_CS    = cs_r;
    assign o_DC    = dc_r;
    assign o_DONE  = done_r;
    assign o_BUSY  = busy_r;

endmodule

// File: tb/tb_spi_tx_fifo_master.sv
// Directed bench for spi_tx_fifo_master. Instance a uses the default
// parameters; instance b uses WIDTH=16, CLK_DIV=1, LSB_FIRST=1.
module tb_spi_tx_fifo_master;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0]  a_data = 8'h00;
    logic        a_dc_in = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_sck, a_mosi, a_cs, a_dc, a_done, a_busy;
    logic [2:0]  a_count;

    logic [15:0] b_data = 16'h0000;
    logic        b_dc_in = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_sck, b_mosi, b_cs, b_dc, b_done, b_busy;
    logic [2:0]  b_count;

    int vectors = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    spi_tx_fifo_master dut_a (
        .i_CLK(clk), .i_RST(rst), .i_DATA(a_data), .i_DC(a_dc_in), .i_VALID(a_valid),
        .o_READY(a_ready), .o_SCK(a_sck), .o_MOSI(a_mosi), .o_CS(a_cs), .o_DC(a_dc),
        .o_DONE(a_done), .o_BUSY(a_busy), .o_COUNT(a_count)
    );

    spi_tx_fifo_master #(.WIDTH(16), .DEPTH(4), .CLK_DIV(1), .LSB_FIRST(1), .CS_GAP(2)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_DATA(b_data), .i_DC(b_dc_in), .i_VALID(b_valid),
        .o_READY(b_ready), .o_SCK(b_sck), .o_MOSI(b_mosi), .o_CS(b_cs), .o_DC(b_dc),
        .o_DONE(b_done), .o_BUSY(b_busy), .o_COUNT(b_count)
    );

    // Edge counter; read at the falling edge it names the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state for instance a.
    logic a_sck_p = 1'b1, a_cs_p = 1'b1, a_dc_p = 1'b0, a_busy_p = 1'b0, a_mosi_p = 1'b0;
    int   a_fall_cyc = 0, a_rise_cyc = 0, a_viol = 0;
    logic a_bits[$];
    logic a_dcs[$];
    int   a_done_cyc[$];
    int   a_fall_q[$];
    int   a_cs_len[$];
    int   a_idle_len[$];
    int   a_dc_rise[$];
    logic a_dc_rise_sckf[$];

    // Record what instance a puts on the wire, sampled between clock edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_sck && !a_sck_p && !a_cs) begin
                a_bits.push_back(a_mosi);
                a_dcs.push_back(a_dc);
            end
            if (a_done) a_done_cyc.push_back(cyc);
            if (!a_cs && a_cs_p) begin
                a_fall_cyc <= cyc;
                a_fall_q.push_back(cyc);
            end
            if (a_cs && !a_cs_p) begin
                a_cs_len.push_back(cyc - a_fall_cyc);
                a_rise_cyc <= cyc;
            end
            if (!a_busy && a_busy_p) a_idle_len.push_back(cyc - a_rise_cyc);
            if (a_dc && !a_dc_p) begin
                a_dc_rise.push_back(cyc - a_fall_cyc);
                a_dc_rise_sckf.push_back(!a_sck && a_sck_p);
            end
            if (!a_cs && !a_cs_p && a_sck && (a_mosi != a_mosi_p || a_dc != a_dc_p)) a_viol <= a_viol + 1;
        end
        a_sck_p  <= a_sck;
        a_cs_p   <= a_cs;
        a_dc_p   <= a_dc;
        a_busy_p <= a_busy;
        a_mosi_p <= a_mosi;
    end

    // Monitor state for instance b.
    logic b_sck_p = 1'b1, b_cs_p = 1'b1, b_mosi_p = 1'b0;
    int   b_fall_cyc = 0, b_viol = 0, b_done_n = 0;
    logic b_bits[$];
    int   b_cs_len[$];

    // Record what instance b puts on the wire.
    always @(negedge clk) begin
        if (!rst) begin
            if (b_sck && !b_sck_p && !b_cs) b_bits.push_back(b_mosi);
            if (b_done) b_done_n <= b_done_n + 1;
            if (!b_cs && b_cs_p) b_fall_cyc <= cyc;
            if (b_cs && !b_cs_p) b_cs_len.push_back(cyc - b_fall_cyc);
            if (!b_cs && !b_cs_p && b_sck && b_mosi != b_mosi_p) b_viol <= b_viol + 1;
        end
        b_sck_p  <= b_sck;
        b_cs_p   <= b_cs;
        b_mosi_p <= b_mosi;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Pack n sampled bits of instance a, first sample most significant.
    function automatic logic [63:0] pack_a_bits(input int idx, input int n);
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v = {v[62:0], a_bits[idx + k]};
        return v;
    endfunction

    function automatic logic [63:0] pack_a_dcs(input int idx, input int n);
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v = {v[62:0], a_dcs[idx + k]};
        return v;
    endfunction

    // Called at a falling edge; the push is taken on the next rising edge.
    task automatic push_a(input logic [7:0] d, input logic dc);
        a_data = d;
        a_dc_in = dc;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    int bb, bc, bd, bf, bi, br, push_cyc, done_snap, fall_snap;
    logic [7:0] wrap_data [10] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h99, 8'h66, 8'h01, 8'h80, 8'hE7, 8'h3D};
    logic       wrap_dc   [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] full_cnt  [6]  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       full_rdy  [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        // ---- reset values ----
        #1 rst = 1'b1;
        #1;
        check("rst_a_outputs", {a_sck, a_cs, a_mosi, a_dc, a_done, a_busy, a_ready, a_count},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        check("rst_b_outputs", {b_sck, b_cs, b_mosi, b_dc, b_done, b_busy, b_ready, b_count},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- single word 0xAF, DC=0 ----
        bb = a_bits.size(); bc = a_cs_len.size(); bd = a_done_cyc.size();
        bf = a_fall_q.size(); bi = a_idle_len.size();
        push_a(8'hAF, 1'b0);
        push_cyc = cyc;
        check("single_count_after_push", {61'd0, a_count}, 64'd1);
        check("single_cs_before_pop", {63'd0, a_cs}, 64'd1);
        @(negedge clk);
        check("single_cs_low_after_pop", {63'd0, a_cs}, 64'd0);
        check("single_count_after_pop", {61'd0, a_count}, 64'd0);
        repeat (50) @(negedge clk);
        check("single_bit_count", 64'(a_bits.size() - bb), 64'd8);
        check("single_bits", pack_a_bits(bb, 8), 64'hAF);
        check("single_cs_low_len", 64'(a_cs_len[bc]), 64'd34);
        check("single_cs_fall_latency", 64'(a_fall_q[bf] - push_cyc), 64'd1);
        check("single_done_count", 64'(a_done_cyc.size() - bd), 64'd1);
        check("single_done_time", 64'(a_done_cyc[bd] - a_fall_q[bf]), 64'd34);
        check("single_gap_len", 64'(a_idle_len[bi]), 64'd2);
        check("single_idle_end", {62'd0, a_busy, a_cs}, 64'd1);

        // ---- burst 0x15 (DC0), 0x3C, 0x81 (DC1) ----
        bb = a_bits.size(); bc = a_cs_len.size(); bd = a_done_cyc.size();
        br = a_dc_rise.size();
        push_a(8'h15, 1'b0);
        push_a(8'h3C, 1'b1);
        push_a(8'h81, 1'b1);
        repeat (120) @(negedge clk);
        check("burst_cs_windows", 64'(a_cs_len.size() - bc), 64'd1);
        check("burst_cs_low_len", 64'(a_cs_len[bc]), 64'd98);
        check("burst_bits", pack_a_bits(bb, 24), 64'h153C81);
        check("burst_dc_per_bit", pack_a_dcs(bb, 24), 64'h00FFFF);
        check("burst_dc_rise_time", 64'(a_dc_rise[br]), 64'd34);
        check("burst_dc_rise_on_sck_fall", {63'd0, a_dc_rise_sckf[br]}, 64'd1);
        check("burst_done_count", 64'(a_done_cyc.size() - bd), 64'd3);
        check("burst_done_spacing_1", 64'(a_done_cyc[bd + 1] - a_done_cyc[bd]), 64'd32);
        check("burst_done_spacing_2", 64'(a_done_cyc[bd + 2] - a_done_cyc[bd + 1]), 64'd32);

        // ---- FIFO full: six consecutive push attempts ----
        bb = a_bits.size(); bc = a_cs_len.size(); bd = a_done_cyc.size();
        a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 8'(i + 1);
            a_dc_in = 1'(i % 2);
            @(negedge clk);
            check($sformatf("full_count_step%0d", i), {61'd0, a_count}, {61'd0, full_cnt[i]});
            check($sformatf("full_ready_step%0d", i), {63'd0, a_ready}, {63'd0, full_rdy[i]});
        end
        a_valid = 1'b0;
        repeat (200) @(negedge clk);
        check("full_words_sent", 64'(a_bits.size() - bb), 64'd40);
        check("full_bits", pack_a_bits(bb, 40), 64'h0102030405);
        check("full_dc_per_bit", pack_a_dcs(bb, 40), 64'h00FF00FF00);
        check("full_cs_low_len", 64'(a_cs_len[bc]), 64'd162);
        check("full_done_count", 64'(a_done_cyc.size() - bd), 64'd5);
        check("full_ready_after", {63'd0, a_ready}, 64'd1);

        // ---- wrap-around: ten isolated words ----
        for (int w = 0; w < 10; w++) begin
            bb = a_bits.size(); bc = a_cs_len.size();
            push_a(wrap_data[w], wrap_dc[w]);
            repeat (45) @(negedge clk);
            check($sformatf("wrap_bits_%0d", w), pack_a_bits(bb, 8), {56'd0, wrap_data[w]});
            check($sformatf("wrap_dc_%0d", w), pack_a_dcs(bb, 8), {56'd0, {8{wrap_dc[w]}}});
            check($sformatf("wrap_cs_len_%0d", w), 64'(a_cs_len[bc]), 64'd34);
        end
        check("a_stable_during_high", 64'(a_viol), 64'd0);

        // ---- instance b: LSB first, 16 bits, CLK_DIV=1 ----
        bb = b_bits.size(); bc = b_cs_len.size(); bd = b_done_n;
        b_data = 16'h8001;
        b_dc_in = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        repeat (45) @(negedge clk);
        check("lsb_bit_count", 64'(b_bits.size() - bb), 64'd16);
        check("lsb_first_bit", {63'd0, b_bits[bb]}, 64'd1);
        check("lsb_last_bit", {63'd0, b_bits[bb + 15]}, 64'd1);
        begin
            logic [15:0] v = 16'h0000;
            for (int k = 0; k < 16; k++) v[k] = b_bits[bb + k];
            check("lsb_word", {48'd0, v}, 64'h8001);
        end
        check("lsb_cs_low_len", 64'(b_cs_len[bc]), 64'd33);
        check("lsb_done_count", 64'(b_done_n - bd), 64'd1);
        check("b_stable_during_high", 64'(b_viol), 64'd0);

        // ---- reset mid-frame on 0xA5 ----
        bb = a_bits.size();
        push_a(8'hA5, 1'b1);
        for (int t = 0; t < 100 && a_bits.size() < bb + 3; t++) @(negedge clk);
        check("midrst_reached_bit3", {63'd0, a_bits.size() >= bb + 3}, 64'd1);
        check("midrst_in_frame", {61'd0, a_cs, a_mosi, a_dc}, 64'd3);
        done_snap = a_done_cyc.size();
        fall_snap = a_fall_q.size();
        #1 rst = 1'b1;
        #1;
        check("midrst_outputs", {a_sck, a_cs, a_mosi, a_dc, a_done, a_busy, a_ready, a_count},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 64'(a_done_cyc.size() - done_snap), 64'd0);
        check("midrst_no_restart", 64'(a_fall_q.size() - fall_snap), 64'd0);
        check("midrst_idle_after", {60'd0, a_cs, a_sck, a_busy, a_ready}, 64'hD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
